// File: rtl/i2c_fifo.sv
// i2c_fifo: single-clock synchronous FIFO, DEPTH = 2**AWIDTH words.
// Reads are registered: DATA_OUT updates on the edge that accepts the read
// and holds otherwise. ERROR is a registered one-cycle pulse that follows
// any edge where a write hit a full FIFO without a paired read, or a read
// hit an empty FIFO.
module i2c_fifo #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 4
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              WR_ENA,
    input  logic              RD_ENA,
    input  logic [DWIDTH-1:0] DATA_IN,
    output logic [DWIDTH-1:0] DATA_OUT,
    output logic              FULL,
    output logic              EMPTY,
    output logic [AWIDTH:0]   COUNT,
    output logic              ERROR
);

    localparam int              DEPTH    = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] CNT_FULL = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH:0] CNT_ZERO = '0;
    localparam logic [AWIDTH:0] CNT_ONE  = (AWIDTH + 1)'(1);
    localparam logic [AWIDTH-1:0] PTR_ONE = AWIDTH'(1);

    // Storage is deliberately not reset; words only become visible after
    // they are written, so their power-up contents never matter.
    logic [DWIDTH-1:0] mem_q [DEPTH];

    logic [AWIDTH-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q,   rd_ptr_d;
    logic [AWIDTH:0]   count_q,    count_d;
    logic [DWIDTH-1:0] data_out_q, data_out_d;
    logic              error_q,    error_d;

    logic full;
    logic empty;
    logic rd_acc;
    logic wr_acc;
    logic overflow;
    logic underflow;

    // Status flags and request acceptance, all decoded from registered COUNT.
    always_comb begin
        full  = (count_q == CNT_FULL);
        empty = (count_q == CNT_ZERO);
        // A read frees a slot on the same edge, so a full FIFO still takes
        // a write when it is paired with a read.
        rd_acc    = RD_ENA && !empty;
        wr_acc    = WR_ENA && (!full || rd_acc);
        overflow  = WR_ENA && full && !RD_ENA;
        underflow = RD_ENA && empty;
    end

    // Next-state for pointers, occupancy, read data and the error pulse.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        error_d    = overflow || underflow;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            // When full with a paired write both pointers are equal; the
            // memory write is non-blocking so the oldest word is read here.
            data_out_d = mem_q[rd_ptr_q];
        end

        // Acceptance rules already keep COUNT within 0..DEPTH.
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            error_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            error_q    <= error_d;
        end
    end

    // Storage array write port; no reset so it maps onto plain RAM.
    always_ff @(posedge PCLK) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= DATA_IN;
        end
    end

    assign DATA_OUT = data_out_q;
    assign COUNT    = count_q;
    assign FULL     = full;
    assign EMPTY    = empty;
    assign ERROR    = error_q;

endmodule
